// File: rtl/uart_echo_ctrl.sv
// Echo sequencer between UART RX and TX FIFOs: pop, add INC, push.
// Statistics counters are built only when UART_ECHO_STATS_EN is defined.
module uart_echo_ctrl #(
  parameter int DATA_W      = 8,
  parameter int INC         = 1,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              step,
  input  logic              rx_empty,
  input  logic [DATA_W-1:0] r_data,
  input  logic              tx_full,
  output logic              rd_uart,
  output logic              wr_uart,
  output logic [DATA_W-1:0] w_data,
  output logic              busy,
  output logic [CNT_W-1:0]  byte_cnt,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t            state_q, state_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] w_data_q, w_data_d;
  logic              step_pend_q, step_pend_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              go;
  logic              tmo_hit;

  function automatic logic [DATA_W-1:0] wrap_inc(input logic [DATA_W-1:0] b);
    return b + DATA_W'(INC);
  endfunction

  // A step arriving this cycle counts as pending immediately, so the pop
  // can happen on the same edge that would otherwise only latch the request.
  assign go      = en | step | step_pend_q;
  assign tmo_hit = (TIMEOUT_CYC != 0) && (tmo_q == TMO_LAST);

  always_comb begin
    state_d     = state_q;
    rd_d        = 1'b0;
    wr_d        = 1'b0;
    w_data_d    = w_data_q;
    tmo_d       = tmo_q;
    step_pend_d = step_pend_q | step;
    case (state_q)
      IDLE: begin
        if (go && !rx_empty) begin
          rd_d        = 1'b1;
          w_data_d    = wrap_inc(r_data);
          step_pend_d = 1'b0;
          state_d     = WRITE;
        end
      end
      WRITE: begin
        if (!tx_full) begin
          wr_d    = 1'b1;
          tmo_d   = '0;
          state_d = DONE;
        end else if (tmo_hit) begin
          tmo_d   = '0;
          state_d = DONE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      busy_q      <= 1'b0;
      w_data_q    <= '0;
      step_pend_q <= 1'b0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      busy_q      <= busy_d;
      w_data_q    <= w_data_d;
      step_pend_q <= step_pend_d;
      tmo_q       <= tmo_d;
    end
  end

  assign rd_uart = rd_q;
  assign wr_uart = wr_q;
  assign busy    = busy_q;
  assign w_data  = w_data_q;

`ifdef UART_ECHO_STATS_EN
  logic [CNT_W-1:0] byte_cnt_q;
  logic [CNT_W-1:0] drop_cnt_q;
  logic             drop_evt;

  assign drop_evt = (state_q == WRITE) && tx_full && tmo_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (wr_d)     byte_cnt_q <= byte_cnt_q + CNT_W'(1);
      if (drop_evt) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
    end
  end

  assign byte_cnt = byte_cnt_q;
  assign drop_cnt = drop_cnt_q;
`else
  assign byte_cnt = '0;
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_uart_echo_ctrl.sv
// Bench for uart_echo_ctrl: instance 0 waits forever on tx_full, instance 1 drops after 4 cycles.
module tb_uart_echo_ctrl;

`ifdef UART_ECHO_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  typedef struct {
    logic [7:0] din;
    logic [7:0] dexp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        en[2], step[2], rx_empty[2], tx_full[2];
  logic [7:0]  r_data[2];
  logic        rd[2], wr[2], busy[2];
  logic [7:0]  w_data[2];
  logic [15:0] byte_cnt[2], drop_cnt[2];

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;
  logic prev_rd[2], prev_wr[2];
  int   rd_seen[2], wr_seen[2];
  logic [7:0] rxq0[$], rxq1[$], expq0[$], expq1[$];
  vec_t vtab[5];

  always #5 clk = ~clk;

  uart_echo_ctrl #(.DATA_W(8), .INC(1), .CNT_W(16), .TIMEOUT_CYC(0)) u_dut0 (
    .clk(clk), .rst(rst), .en(en[0]), .step(step[0]), .rx_empty(rx_empty[0]),
    .r_data(r_data[0]), .tx_full(tx_full[0]), .rd_uart(rd[0]), .wr_uart(wr[0]),
    .w_data(w_data[0]), .busy(busy[0]), .byte_cnt(byte_cnt[0]), .drop_cnt(drop_cnt[0]));

  uart_echo_ctrl #(.DATA_W(8), .INC(1), .CNT_W(16), .TIMEOUT_CYC(4)) u_dut1 (
    .clk(clk), .rst(rst), .en(en[1]), .step(step[1]), .rx_empty(rx_empty[1]),
    .r_data(r_data[1]), .tx_full(tx_full[1]), .rd_uart(rd[1]), .wr_uart(wr[1]),
    .w_data(w_data[1]), .busy(busy[1]), .byte_cnt(byte_cnt[1]), .drop_cnt(drop_cnt[1]));

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  task automatic sync_rx();
    rx_empty[0] = (rxq0.size() == 0);
    r_data[0]   = (rxq0.size() != 0) ? rxq0[0] : 8'h00;
    rx_empty[1] = (rxq1.size() == 0);
    r_data[1]   = (rxq1.size() != 0) ? rxq1[0] : 8'h00;
  endtask

  task automatic push_rx(input int k, input logic [7:0] b, input bit has_exp, input logic [7:0] e);
    if (k == 0) begin
      rxq0.push_back(b);
      if (has_exp) expq0.push_back(e);
    end else begin
      rxq1.push_back(b);
      if (has_exp) expq1.push_back(e);
    end
    sync_rx();
  endtask

  task automatic cyc();
    int n;
    logic [7:0] e;
    @(posedge clk);
    #1;
    cyc_n++;
    for (int k = 0; k < 2; k++) begin
      chk("rd_wr_exclusive", int'(rd[k] & wr[k]), 0);
      chk("rd_back_to_back", int'(prev_rd[k] & rd[k]), 0);
      chk("wr_back_to_back", int'(prev_wr[k] & wr[k]), 0);
      if (rd[k]) begin
        rd_seen[k]++;
        if (k == 0) begin if (rxq0.size() != 0) void'(rxq0.pop_front()); end
        else        begin if (rxq1.size() != 0) void'(rxq1.pop_front()); end
      end
      if (wr[k]) begin
        wr_seen[k]++;
        n = (k == 0) ? expq0.size() : expq1.size();
        if (n == 0) chk("sb_unexpected_wr", 1, 0);
        else begin
          e = (k == 0) ? expq0.pop_front() : expq1.pop_front();
          chk("sb_w_data", int'(w_data[k]), int'(e));
        end
      end
      prev_rd[k] = rd[k];
      prev_wr[k] = wr[k];
    end
    sync_rx();
  endtask

  task automatic wait_wr(input int k, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      cyc();
      if (wr[k]) begin
        at = cyc_n;
        break;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 required 0");
    $fatal(1, "bench time limit");
  end

  initial begin
    int at, prev_at, s, nb, wr_before;
    vtab[0] = '{8'h00, 8'h01};
    vtab[1] = '{8'h7F, 8'h80};
    vtab[2] = '{8'hFF, 8'h00};
    vtab[3] = '{8'h41, 8'h42};
    vtab[4] = '{8'h80, 8'h81};
    for (int k = 0; k < 2; k++) begin
      en[k] = 1'b0; step[k] = 1'b0; tx_full[k] = 1'b0;
      prev_rd[k] = 1'b0; prev_wr[k] = 1'b0; rd_seen[k] = 0; wr_seen[k] = 0;
    end
    rst = 1'b1;
    sync_rx();
    cyc(); cyc();
    for (int k = 0; k < 2; k++) begin
      chk("reset_rd", int'(rd[k]), 0);
      chk("reset_wr", int'(wr[k]), 0);
      chk("reset_busy", int'(busy[k]), 0);
      chk("reset_w_data", int'(w_data[k]), 0);
      chk("reset_byte_cnt", int'(byte_cnt[k]), 0);
      chk("reset_drop_cnt", int'(drop_cnt[k]), 0);
    end
    rst = 1'b0;
    cyc();

    // step mode: single byte, fixed latency
    push_rx(0, 8'h41, 1, 8'h42);
    step[0] = 1'b1;
    cyc();
    step[0] = 1'b0;
    chk("t1_rd_at_t1", int'(rd[0]), 1);
    chk("t1_wr_not_at_t1", int'(wr[0]), 0);
    chk("t1_busy", int'(busy[0]), 1);
    cyc();
    chk("t1_wr_at_t2", int'(wr[0]), 1);
    chk("t1_w_data", int'(w_data[0]), 8'h42);
    s = rd_seen[0] + wr_seen[0];
    repeat (8) cyc();
    chk("t1_no_more_strobes", rd_seen[0] + wr_seen[0] - s, 0);
    chk("t1_idle", int'(busy[0]), 0);
    chk("t1_sb_empty", expq0.size(), 0);

    // auto mode over the vector table, incl. 8'hFF wrap
    for (int i = 0; i < 5; i++) push_rx(0, vtab[i].din, 1, vtab[i].dexp);
    en[0] = 1'b1;
    prev_at = -1;
    for (int i = 0; i < 5; i++) begin
      wait_wr(0, 12, at);
      chk("t2_wr_arrived", int'(at >= 0), 1);
      if (i > 0 && at >= 0 && prev_at >= 0) chk("t2_wr_spacing", at - prev_at, 3);
      prev_at = at;
    end
    chk("t2_last_w_data", int'(w_data[0]), 8'h81);
    en[0] = 1'b0;
    repeat (3) cyc();
    chk("t2_byte_cnt", int'(byte_cnt[0]), STATS ? 6 : 0);
    chk("t2_sb_empty", expq0.size(), 0);
    chk("t2_idle", int'(busy[0]), 0);

    // backpressure with no timeout: pop still happens, write waits
    tx_full[0] = 1'b1;
    push_rx(0, 8'h10, 1, 8'h11);
    step[0] = 1'b1;
    cyc();
    step[0] = 1'b0;
    chk("t3_rd_while_full", int'(rd[0]), 1);
    s = 0; nb = 0;
    repeat (50) begin
      cyc();
      if (wr[0]) s++;
      if (!busy[0]) nb++;
    end
    chk("t3_no_wr_while_full", s, 0);
    chk("t3_busy_while_full", nb, 0);
    tx_full[0] = 1'b0;
    cyc();
    chk("t3_wr_after_release", int'(wr[0]), 1);
    chk("t3_w_data", int'(w_data[0]), 8'h11);
    cyc(); cyc();
    chk("t3_idle", int'(busy[0]), 0);
    chk("t3_drop_cnt", int'(drop_cnt[0]), 0);

    // timeout drop on instance 1
    tx_full[1] = 1'b1;
    push_rx(1, 8'h20, 0, 8'h00);
    step[1] = 1'b1;
    cyc();
    step[1] = 1'b0;
    chk("t4_rd", int'(rd[1]), 1);
    wr_before = wr_seen[1];
    repeat (3) cyc();
    chk("t4_no_early_drop", int'(drop_cnt[1]), 0);
    chk("t4_busy_waiting", int'(busy[1]), 1);
    cyc();
    chk("t4_drop_cnt", int'(drop_cnt[1]), STATS ? 1 : 0);
    chk("t4_busy_in_done", int'(busy[1]), 1);
    cyc();
    chk("t4_back_idle", int'(busy[1]), 0);
    chk("t4_no_wr_on_drop", wr_seen[1] - wr_before, 0);
    tx_full[1] = 1'b0;
    push_rx(1, 8'h30, 1, 8'h31);
    step[1] = 1'b1;
    cyc();
    step[1] = 1'b0;
    chk("t4_next_rd", int'(rd[1]), 1);
    cyc();
    chk("t4_next_wr", int'(wr[1]), 1);
    chk("t4_next_w_data", int'(w_data[1]), 8'h31);
    chk("t4_byte_cnt", int'(byte_cnt[1]), STATS ? 1 : 0);

    // pending steps with empty RX collapse into a single echo
    s = rd_seen[0];
    step[0] = 1'b1; cyc(); step[0] = 1'b0;
    cyc(); cyc();
    step[0] = 1'b1; cyc(); step[0] = 1'b0;
    repeat (4) cyc();
    chk("t5_nothing_while_empty", rd_seen[0] - s, 0);
    chk("t5_idle_while_empty", int'(busy[0]), 0);
    push_rx(0, 8'h55, 1, 8'h56);
    wait_wr(0, 6, at);
    chk("t5_one_echo", int'(at >= 0), 1);
    repeat (3) cyc();
    push_rx(0, 8'h66, 0, 8'h00);
    s = rd_seen[0];
    repeat (10) cyc();
    chk("t5_second_not_echoed", rd_seen[0] - s, 0);
    chk("t5_idle_after", int'(busy[0]), 0);
    rxq0.delete();
    sync_rx();

    // reset while holding a byte in WRITE
    tx_full[0] = 1'b1;
    push_rx(0, 8'h77, 0, 8'h00);
    step[0] = 1'b1;
    cyc();
    step[0] = 1'b0;
    chk("t6_rd", int'(rd[0]), 1);
    cyc();
    chk("t6_busy_in_write", int'(busy[0]), 1);
    rst = 1'b1;
    cyc();
    chk("t6_rst_rd", int'(rd[0]), 0);
    chk("t6_rst_wr", int'(wr[0]), 0);
    chk("t6_rst_busy", int'(busy[0]), 0);
    chk("t6_rst_w_data", int'(w_data[0]), 0);
    chk("t6_rst_byte_cnt", int'(byte_cnt[0]), 0);
    chk("t6_rst_drop_cnt", int'(drop_cnt[1]), 0);
    rst = 1'b0;
    tx_full[0] = 1'b0;
    s = wr_seen[0];
    repeat (6) cyc();
    chk("t6_no_wr_after_rst", wr_seen[0] - s, 0);
    chk("t6_idle", int'(busy[0]), 0);

    chk("final_sb0_empty", expq0.size(), 0);
    chk("final_sb1_empty", expq1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
